regs_file: RTL and testbench
============================

// Module: regs_file
// PURPOSE
//  Integer register file (x0..x31): the responder to the decode stage's rs1/rs2 read requests.
//  Sits between decode (read addresses in) and execute (operands out).
//  Writeback drives the single write port.
//  Two combinational read ports plus one debug read port; write-to-read bypass; x0 hardwired to zero.
// PARAMETERS
//  REG_NUM   32  number of architectural registers (address width = 5)
//  DATA_W    32  register width in bits
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst_n        in   1      reset, synchronous, active-low
//  rs1_addr_i   in   5      read port 1 address (from decode)
//  rs2_addr_i   in   5      read port 2 address (from decode)
//  rs1_data_o   out  32     read port 1 data (to execute)
//  rs2_data_o   out  32     read port 2 data (to execute)
//  rd_we_i      in   1      write enable (from writeback)
//  rd_addr_i    in   5      write address
//  rd_data_i    in   32     write data
//  dbg_addr_i   in   5      debug read address
//  dbg_data_o   out  32     debug read data (registered)
//  dbg_valid_o  out  1      high one cycle after a debug read is captured
//  dbg_req_i    in   1      debug read request
// BEHAVIOUR
//  Reset (clk edge with rst_n=0)
//   - All regs[1..31] <= 0; dbg_data_o <= 0; dbg_valid_o <= 0.
//   - A write presented in the same cycle is dropped.
//   - While rst_n=0: rs1_data_o = rs2_data_o = 0 (combinational force).
//  Write
//   - On a rising edge with rst_n=1, rd_we_i=1 and rd_addr_i!=0: regs[rd_addr_i] <= rd_data_i.
//   - Writes to x0 are ignored.
//   - Single write port; no write collisions are possible.
//  Read ports 1/2 (combinational, 0-cycle latency)
//   - addr==0 -> 0, always, including when a write to x0 is pending.
//   - rd_we_i=1 and rd_addr_i==addr!=0 -> rd_data_i (same-cycle bypass: write-then-read semantics).
//   - Otherwise -> regs[addr].
//   - Both ports are independent; both may read the same register or bypass simultaneously.
//  Debug port (registered, 1-cycle latency)
//   - Edge with dbg_req_i=1: dbg_data_o <= value read-port rules give for dbg_addr_i (bypass included).
//     Also dbg_valid_o <= 1.
//   - Edge with dbg_req_i=0: dbg_valid_o <= 0; dbg_data_o holds.
//   - Back-to-back requests give one result per cycle; dbg_valid_o stays high.
//  Width rules: addresses are 5 bits; no out-of-range handling is needed for REG_NUM=32.
//   - For REG_NUM<32, addresses >= REG_NUM read 0 and writes to them are dropped.
//  No internal state machine; state is the register array plus the debug output registers.
// TESTING
//  1 Reset: hold rst_n=0 two cycles with rd_we_i=1, rd_addr_i=5, rd_data_i=0xDEAD_BEEF.
//    -> After release, rs1_addr_i=5 reads 0 and all 31 registers read 0.
//  2 Write/read: write x7=0x1234_5678; next cycle rs1_addr_i=7, rs2_addr_i=7 -> both 0x1234_5678.
//  3 x0: write x0=0xFFFF_FFFF with rs1_addr_i=0 in the same cycle.
//    -> rs1_data_o=0 that cycle and every later cycle.
//  4 Bypass: x3 holds 0x11. Present write x3=0x22 with rs2_addr_i=3.
//    -> rs2_data_o=0x22 in the same cycle; rs1_addr_i=4 is unaffected.
//  5 Debug: dbg_req_i=1, dbg_addr_i=7 for 2 cycles, then 0.
//    -> dbg_valid_o=1 for 2 cycles, dbg_data_o=0x1234_5678, then valid=0 and data holds.
//  6 Reset mid-run: after test 2, assert rst_n=0 one edge.
//    -> x7 reads 0, dbg_valid_o=0, and the write in the reset cycle is lost.

Source files
------------

// File: rtl/regs_file.sv
// -----------------------------------------------------------------------------
// regs_file
//   Integer register file x0..x31 serving the decode stage's rs1/rs2 operand
//   reads, written by writeback through a single write port.
//
//   - Two combinational read ports with same-cycle write-to-read bypass.
//   - x0 always reads zero; writes to x0 are discarded.
//   - One registered debug read port with a one-cycle valid strobe.
//   - Synchronous active-low reset clears every register and the debug
//     outputs. While reset is low, both operand ports are forced to zero.
//
// Parameters
//   REG_NUM      number of architectural registers (at most 32)
//   DATA_W       register width in bits
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   rs1_addr_i   read port 1 address (from decode)
//   rs2_addr_i   read port 2 address (from decode)
//   rs1_data_o   read port 1 data (to execute), combinational
//   rs2_data_o   read port 2 data (to execute), combinational
//   rd_we_i      write enable (from writeback)
//   rd_addr_i    write address
//   rd_data_i    write data
//   dbg_req_i    debug read request
//   dbg_addr_i   debug read address
//   dbg_data_o   debug read data, registered
//   dbg_valid_o  high for one cycle after each captured debug read
// -----------------------------------------------------------------------------
module regs_file #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs1_addr_i,
    input  logic [4:0]        rs2_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    input  logic              rd_we_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [4:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic              dbg_valid_o,
    input  logic              dbg_req_i
);

    localparam int ADDR_W    = 5;
    localparam int NUM_SLOTS = 32;
    // One extra bit so that REG_NUM = 32 is representable for the range test.
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(REG_NUM);

    // Storage is sized to the full address space so every 5-bit address
    // indexes a real slot. Slot 0 and slots at or above REG_NUM are never
    // written after reset, and reads of them are masked to zero anyway.
    logic [DATA_W-1:0] regs_r [NUM_SLOTS];

    logic [DATA_W-1:0] dbg_data_r;
    logic              dbg_valid_r;

    logic              wr_en_s;
    logic [DATA_W-1:0] rs1_val_s;
    logic [DATA_W-1:0] rs2_val_s;
    logic [DATA_W-1:0] dbg_val_s;
    logic [DATA_W-1:0] rs1_out_s;
    logic [DATA_W-1:0] rs2_out_s;

    // True when an address names an implemented register.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < REG_LIMIT);
    endfunction

    // Value a read port presents for addr: zero for x0 and unimplemented
    // registers, the in-flight write data on an address match (write-then-read
    // ordering), otherwise the stored contents.
    function automatic logic [DATA_W-1:0] port_value(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] val;
        if ((addr == {ADDR_W{1'b0}}) || !addr_in_range(addr)) begin
            val = {DATA_W{1'b0}};
        end else if (we && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Qualify the write port: x0 and unimplemented registers are never written.
    always_comb begin
        wr_en_s = 1'b0;
        if (rd_we_i && (rd_addr_i != {ADDR_W{1'b0}}) && addr_in_range(rd_addr_i)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Resolve all three read lookups, bypass included.
    always_comb begin
        rs1_val_s = port_value(rs1_addr_i, regs_r[rs1_addr_i], wr_en_s, rd_addr_i, rd_data_i);
        rs2_val_s = port_value(rs2_addr_i, regs_r[rs2_addr_i], wr_en_s, rd_addr_i, rd_data_i);
        dbg_val_s = port_value(dbg_addr_i, regs_r[dbg_addr_i], wr_en_s, rd_addr_i, rd_data_i);
    end

    // Operand ports read zero for as long as reset is held low.
    always_comb begin
        rs1_out_s = {DATA_W{1'b0}};
        rs2_out_s = {DATA_W{1'b0}};
        if (!rst_n) begin
            rs1_out_s = {DATA_W{1'b0}};
            rs2_out_s = {DATA_W{1'b0}};
        end else begin
            rs1_out_s = rs1_val_s;
            rs2_out_s = rs2_val_s;
        end
    end

    // Register array: clear on reset (dropping any concurrent write), else write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[rd_addr_i] <= rd_data_i;
        end
    end

    // Debug capture: data holds between requests, valid tracks the request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_data_r  <= {DATA_W{1'b0}};
            dbg_valid_r <= 1'b0;
        end else if (dbg_req_i) begin
            dbg_data_r  <= dbg_val_s;
            dbg_valid_r <= 1'b1;
        end else begin
            dbg_valid_r <= 1'b0;
        end
    end

    assign rs1_data_o  = rs1_out_s;
    assign rs2_data_o  = rs2_out_s;
    assign dbg_data_o  = dbg_data_r;
    assign dbg_valid_o = dbg_valid_r;

endmodule

// File: tb/tb_regs_file.sv
// -----------------------------------------------------------------------------
// tb_regs_file
//   Directed scenarios followed by a randomized run, each cycle checked
//   against a behavioural model of the register file (array + debug latch).
// -----------------------------------------------------------------------------
module tb_regs_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, dbg_addr_i;
    logic [31:0] rs1_data_o, rs2_data_o, rd_data_i, dbg_data_o;
    logic        rd_we_i, dbg_req_i, dbg_valid_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] model_mem [32];
    logic [31:0] exp_dbg_data;
    logic        exp_dbg_valid;

    // Sampled DUT outputs of the latest step
    logic [31:0] obs_rs1, obs_rs2, obs_dbg;
    logic        obs_valid;

    regs_file #(.REG_NUM(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o),
        .rd_we_i     (rd_we_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_i   (rd_data_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_data_o  (dbg_data_o),
        .dbg_valid_o (dbg_valid_o),
        .dbg_req_i   (dbg_req_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural read as seen with the currently presented inputs.
    function automatic logic [31:0] ref_read(input logic [4:0] addr);
        if (addr == 5'd0)                        return 32'd0;
        else if (rd_we_i && rd_addr_i == addr)   return rd_data_i;
        else                                     return model_mem[addr];
    endfunction

    // One clock cycle: drive at negedge, check read ports, clock, check debug.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                        input logic dreq, input logic [4:0] da);
        logic [31:0] e1, e2;
        @(negedge clk);
        rst_n = rst; rd_we_i = we; rd_addr_i = wa; rd_data_i = wd;
        rs1_addr_i = a1; rs2_addr_i = a2; dbg_req_i = dreq; dbg_addr_i = da;
        #1;
        e1 = rst ? ref_read(a1) : 32'd0;
        e2 = rst ? ref_read(a2) : 32'd0;
        obs_rs1 = rs1_data_o;
        obs_rs2 = rs2_data_o;
        check("rs1_data", obs_rs1, e1);
        check("rs2_data", obs_rs2, e2);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
            exp_dbg_data  = 32'd0;
            exp_dbg_valid = 1'b0;
        end else begin
            if (dreq) begin
                exp_dbg_data  = ref_read(da);
                exp_dbg_valid = 1'b1;
            end else begin
                exp_dbg_valid = 1'b0;
            end
            if (we && wa != 5'd0) model_mem[wa] = wd;
        end
        #1;
        obs_dbg   = dbg_data_o;
        obs_valid = dbg_valid_o;
        check("dbg_data", obs_dbg, exp_dbg_data);
        check("dbg_valid", {31'd0, obs_valid}, {31'd0, exp_dbg_valid});
    endtask

    initial begin
        rst_n = 1'b0; rd_we_i = 1'b0; rd_addr_i = 5'd0; rd_data_i = 32'd0;
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; dbg_req_i = 1'b0; dbg_addr_i = 5'd0;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'hxxxx_xxxx;
        exp_dbg_data = 32'd0; exp_dbg_valid = 1'b0;

        // 1: reset with a write presented; the write must be lost
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0);
        check("reset_x5", obs_rs1, 32'd0);
        for (int i = 1; i < 32; i++) begin
            step(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i), 1'b0, 5'd0);
            check("reset_all", obs_rs1, 32'd0);
        end

        // 2: write then read on both ports
        step(1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0);
        check("x7_rs1", obs_rs1, 32'h1234_5678);
        check("x7_rs2", obs_rs2, 32'h1234_5678);

        // 3: x0 stays zero even with a pending write to it
        step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 5'd0);
        check("x0_same", obs_rs1, 32'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0);
        check("x0_later", obs_rs1, 32'd0);

        // 4: bypass on port 2, port 1 on another register unaffected
        step(1'b1, 1'b1, 5'd3, 32'h0000_0011, 5'd0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b1, 5'd3, 32'h0000_0022, 5'd4, 5'd3, 1'b0, 5'd0);
        check("bypass_rs2", obs_rs2, 32'h0000_0022);
        check("bypass_rs1", obs_rs1, 32'd0);

        // 5: debug back-to-back then idle
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd7);
        check("dbg1_valid", {31'd0, obs_valid}, 32'd1);
        check("dbg1_data", obs_dbg, 32'h1234_5678);
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd7);
        check("dbg2_valid", {31'd0, obs_valid}, 32'd1);
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd3);
        check("dbg_idle_valid", {31'd0, obs_valid}, 32'd0);
        check("dbg_idle_hold", obs_dbg, 32'h1234_5678);
        // debug bypass
        step(1'b1, 1'b1, 5'd9, 32'hCAFE_0009, 5'd0, 5'd0, 1'b1, 5'd9);
        check("dbg_bypass", obs_dbg, 32'hCAFE_0009);

        // 6: reset mid-run with a write and debug request in the reset cycle
        step(1'b0, 1'b1, 5'd10, 32'hAAAA_5555, 5'd7, 5'd7, 1'b1, 5'd7);
        check("rst_force", obs_rs1, 32'd0);
        check("rst_dbg_valid", {31'd0, obs_valid}, 32'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd10, 1'b0, 5'd0);
        check("rst_x7", obs_rs1, 32'd0);
        check("rst_lost_wr", obs_rs2, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 2) != 0),
                 wa,
                 $urandom(),
                 ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
